// File: rtl/write_back_stage_pkg.sv
// Shared types for the write-back stage: register-file write params,
// result source select, load funct3 codes and the stage FSM states.
package write_back_stage_pkg;

    typedef struct packed {
        logic       write_enable;
        logic [4:0] addr_rd;
    } reg_file_write_params_t;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC  = 2'd2
    } write_back_select_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/write_back_stage_load_extract.sv
// Combinational load data extraction: selects byte/half/word from an
// aligned memory word and sign- or zero-extends it.
module load_extract
    import write_back_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign w_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        data = '0;
        unique case (funct3)
            F3_LB:   data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH:   data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, w_half};
            F3_LW:   data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// Write-back stage: registers ALU/PC results or waits for load data.
// Define WB_BYPASS_EN to expose byp_valid/byp_addr/byp_data.
module write_back_stage
    import write_back_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  reg_file_write_params_t in_wr_params,
    input  write_back_select_t     in_sel,
    input  logic [XLEN-1:0]        in_alu_result,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [2:0]             in_load_funct3,
    input  logic [1:0]             in_addr_lo,
    input  logic                   mem_rvalid,
    input  logic [XLEN-1:0]        mem_rdata,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [XLEN-1:0]        rf_wdata,
    output logic                   busy
`ifdef WB_BYPASS_EN
    ,
    output logic                   byp_valid,
    output logic [4:0]             byp_addr,
    output logic [XLEN-1:0]        byp_data
`endif
);

    wb_state_t r_state;
    wb_state_t w_next_state;

    logic            r_ld_we;
    logic [4:0]      r_ld_rd;
    logic [2:0]      r_ld_f3;
    logic [1:0]      r_ld_lo;

    logic            r_rf_we;
    logic [4:0]      r_rf_waddr;
    logic [XLEN-1:0] r_rf_wdata;

    logic            w_accept;
    logic            w_accept_mem;
    logic            w_load_done;
    logic [XLEN-1:0] w_ld_data;
    logic            w_wr_en;
    logic [4:0]      w_wr_addr;
    logic [XLEN-1:0] w_wr_data;

    assign w_accept     = in_valid && (r_state == ST_IDLE);
    assign w_accept_mem = w_accept && (in_sel == WB_SEL_MEM);
    assign w_load_done  = mem_rvalid && (r_state == ST_WAIT_MEM);

    load_extract #(
        .XLEN(XLEN)
    ) u_load_extract (
        .funct3  (r_ld_f3),
        .addr_lo (r_ld_lo),
        .rdata   (mem_rdata),
        .data    (w_ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:     if (w_accept_mem) w_next_state = ST_WAIT_MEM;
            ST_WAIT_MEM: if (mem_rvalid)   w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == ST_IDLE);
        busy     = (r_state == ST_WAIT_MEM);
    end

    // x0 is hardwired, so writes targeting it are suppressed here
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = in_wr_params.addr_rd;
        w_wr_data = in_alu_result;
        if (w_load_done) begin
            w_wr_en   = r_ld_we && (r_ld_rd != 5'd0);
            w_wr_addr = r_ld_rd;
            w_wr_data = w_ld_data;
        end else if (w_accept && !w_accept_mem) begin
            w_wr_en = in_wr_params.write_enable
                      && (in_wr_params.addr_rd != 5'd0);
            if (in_sel == WB_SEL_PC) begin
                w_wr_data = in_pc + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ld_we <= 1'b0;
            r_ld_rd <= '0;
            r_ld_f3 <= '0;
            r_ld_lo <= '0;
        end else if (w_accept_mem) begin
            r_ld_we <= in_wr_params.write_enable;
            r_ld_rd <= in_wr_params.addr_rd;
            r_ld_f3 <= in_load_funct3;
            r_ld_lo <= in_addr_lo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_wr_en;
            if (w_wr_en) begin
                r_rf_waddr <= w_wr_addr;
                r_rf_wdata <= w_wr_data;
            end
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;

`ifdef WB_BYPASS_EN
    assign byp_valid = r_rf_we;
    assign byp_addr  = r_rf_waddr;
    assign byp_data  = r_rf_wdata;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage with a queue-based reference model.
module tb_write_back_stage;
    import write_back_stage_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    reg_file_write_params_t in_wr_params = '0;
    write_back_select_t     in_sel = WB_SEL_ALU;
    logic [31:0]            in_alu_result = '0;
    logic [31:0]            in_pc = '0;
    logic [2:0]             in_load_funct3 = '0;
    logic [1:0]             in_addr_lo = '0;
    logic                   mem_rvalid = 1'b0;
    logic [31:0]            mem_rdata = '0;
    logic                   rf_we;
    logic [4:0]             rf_waddr;
    logic [31:0]            rf_wdata;
    logic                   busy;
`ifdef WB_BYPASS_EN
    logic                   byp_valid;
    logic [4:0]             byp_addr;
    logic [31:0]            byp_data;
`endif

    write_back_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_wr_params   (in_wr_params),
        .in_sel         (in_sel),
        .in_alu_result  (in_alu_result),
        .in_pc          (in_pc),
        .in_load_funct3 (in_load_funct3),
        .in_addr_lo     (in_addr_lo),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .busy           (busy)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid      (byp_valid),
        .byp_addr       (byp_addr),
        .byp_data       (byp_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: pending loads in a queue, expected outputs as values
    typedef struct {
        logic       we;
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] lo;
    } pend_t;

    pend_t       pend[$];
    pend_t       m_p;
    logic        m_we = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    function automatic logic [31:0] m_extract(input logic [2:0] f3,
                                              input logic [1:0] lo,
                                              input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'h0000_00FF;
        h = (w >> (16 * lo[1])) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            3'd2:    return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_put(input logic we, input logic [4:0] rd,
                                  input logic [31:0] d);
        if (we && rd != 5'd0) begin
            m_we   = 1'b1;
            m_addr = rd;
            m_data = d;
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            m_we = 1'b0;
            if (pend.size() != 0) begin
                if (mem_rvalid) begin
                    m_p = pend.pop_front();
                    m_put(m_p.we, m_p.rd, m_extract(m_p.f3, m_p.lo, mem_rdata));
                end
            end else if (in_valid) begin
                if (in_sel == WB_SEL_MEM)
                    pend.push_back('{in_wr_params.write_enable,
                                     in_wr_params.addr_rd,
                                     in_load_funct3, in_addr_lo});
                else if (in_sel == WB_SEL_PC)
                    m_put(in_wr_params.write_enable, in_wr_params.addr_rd,
                          in_pc + 32'd4);
                else
                    m_put(in_wr_params.write_enable, in_wr_params.addr_rd,
                          in_alu_result);
            end
        end
    end

    always @(negedge clk) begin
        check("cmp_ready", {31'd0, in_ready}, {31'd0, pend.size() == 0});
        check("cmp_busy", {31'd0, busy}, {31'd0, pend.size() != 0});
        check("cmp_we", {31'd0, rf_we}, {31'd0, m_we});
        check("cmp_waddr", {27'd0, rf_waddr}, {27'd0, m_addr});
        check("cmp_wdata", rf_wdata, m_data);
`ifdef WB_BYPASS_EN
        check("cmp_byp_valid", {31'd0, byp_valid}, {31'd0, m_we});
        check("cmp_byp_addr", {27'd0, byp_addr}, {27'd0, m_addr});
        check("cmp_byp_data", byp_data, m_data);
`endif
    end

    task automatic send(input write_back_select_t sel, input logic we,
                        input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] f3,
                        input logic [1:0] lo);
        in_valid       = 1'b1;
        in_sel         = sel;
        in_wr_params   = '{write_enable: we, addr_rd: rd};
        in_alu_result  = alu;
        in_pc          = pc;
        in_load_funct3 = f3;
        in_addr_lo     = lo;
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic mem_resp(input logic [31:0] d);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    logic [2:0]  t_f3 [8] = '{3'd4, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd6};
    logic [1:0]  t_lo [8] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
    logic [31:0] t_d  [8] = '{32'h0000_8000, 32'h8001_0000, 32'h0000_7FFF,
                              32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_007F,
                              32'hFFFF_8000, 32'h1234_5678};
    logic [31:0] t_e  [8] = '{32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF,
                              32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_007F,
                              32'h0000_8000, 32'h0000_0000};

    initial begin
        repeat (2) @(negedge clk);
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        mem_resp(32'hFFFF_FFFF);
        check("rvalid_idle_we", {31'd0, rf_we}, 32'd0);
        check("rvalid_idle_busy", {31'd0, busy}, 32'd0);

        send(WB_SEL_ALU, 1'b1, 5'd5, 32'h1234_5678, 32'h0, 3'd0, 2'd0);
        idle();
        check("alu_we", {31'd0, rf_we}, 32'd1);
        check("alu_waddr", {27'd0, rf_waddr}, 32'd5);
        check("alu_wdata", rf_wdata, 32'h1234_5678);

        send(WB_SEL_PC, 1'b1, 5'd1, 32'h0, 32'hFFFF_FFFC, 3'd0, 2'd0);
        idle();
        check("pc_we", {31'd0, rf_we}, 32'd1);
        check("pc_wdata", rf_wdata, 32'h0000_0000);

        send(WB_SEL_MEM, 1'b1, 5'd7, 32'h0, 32'h0, F3_LB, 2'd3);
        check("lb_wait_ready", {31'd0, in_ready}, 32'd0);
        check("lb_wait_busy", {31'd0, busy}, 32'd1);
        send(WB_SEL_ALU, 1'b1, 5'd3, 32'h0000_0BAD, 32'h0, 3'd0, 2'd0);
        idle();
        check("lb_ignore_valid", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        check("lb_still_busy", {31'd0, busy}, 32'd1);
        mem_resp(32'h80FF_0000);
        check("lb_we", {31'd0, rf_we}, 32'd1);
        check("lb_waddr", {27'd0, rf_waddr}, 32'd7);
        check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        check("lb_ready", {31'd0, in_ready}, 32'd1);

        send(WB_SEL_MEM, 1'b1, 5'd9, 32'h0, 32'h0, F3_LHU, 2'd2);
        idle();
        mem_resp(32'hBEEF_1234);
        check("lhu_we", {31'd0, rf_we}, 32'd1);
        check("lhu_wdata", rf_wdata, 32'h0000_BEEF);
        send(WB_SEL_MEM, 1'b1, 5'd0, 32'h0, 32'h0, F3_LHU, 2'd2);
        idle();
        mem_resp(32'h1111_2222);
        check("lhu_x0_we", {31'd0, rf_we}, 32'd0);
        check("lhu_x0_hold", rf_wdata, 32'h0000_BEEF);

        send(WB_SEL_ALU, 1'b0, 5'd4, 32'h0000_CAFE, 32'h0, 3'd0, 2'd0);
        check("store_we", {31'd0, rf_we}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(WB_SEL_ALU, 1'b1, 5'(10 + i), 32'(100 + i), 32'h0, 3'd0, 2'd0);
            check("b2b_we", {31'd0, rf_we}, 32'd1);
            check("b2b_waddr", {27'd0, rf_waddr}, 32'(10 + i));
            check("b2b_wdata", rf_wdata, 32'(100 + i));
        end
        idle();
        @(negedge clk);
        check("b2b_end_we", {31'd0, rf_we}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            send(WB_SEL_MEM, 1'b1, 5'd20, 32'h0, 32'h0, t_f3[i], t_lo[i]);
            idle();
            mem_resp(t_d[i]);
            check("extract", rf_wdata, t_e[i]);
        end

        send(WB_SEL_MEM, 1'b1, 5'd8, 32'h0, 32'h0, F3_LW, 2'd0);
        idle();
        check("rstw_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rstw_ready", {31'd0, in_ready}, 32'd1);
        mem_resp(32'h5555_AAAA);
        check("rstw_we", {31'd0, rf_we}, 32'd0);
        check("rstw_busy0", {31'd0, busy}, 32'd0);
        check("rstw_ready2", {31'd0, in_ready}, 32'd1);
        check("rstw_wdata", rf_wdata, 32'd0);

        send(WB_SEL_ALU, 1'b1, 5'd31, 32'hA5A5_5A5A, 32'h0, 3'd0, 2'd0);
        idle();
        check("post_rst_alu", rf_wdata, 32'hA5A5_5A5A);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
